ahbl_cache_bridge: RTL and testbench
====================================

// Module: ahbl_cache_bridge
// PURPOSE
//  AHB-Lite slave that sits directly upstream of cache_ctrl: Hazard3 bus transfers in, single-pulse
//  rd/wr requests on cache_ctrl's user port out. Captures the address phase, builds the byte mask and
//  issues one request per transfer. Holds hready low until the cache reports completion.
//  Counts reads, cache hits and wait cycles for software profiling.
// PARAMETERS
//  ADDR_WIDTH  23  byte-address bits forwarded to mem_addr; upper bits driven 0
//  CNT_WIDTH   32  width of each saturating profiling counter
// PORTS
//  clk          in   1           system clock (same clock as cache_ctrl)
//  rst_x        in   1           asynchronous, active-low reset
//  hsel         in   1           AHB slave select
//  haddr        in   32          AHB address
//  htrans       in   2           AHB transfer type; only NONSEQ/SEQ (htrans[1]=1) start a transfer
//  hwrite       in   1           1 = write
//  hsize        in   3           0 byte, 1 half, 2 word
//  hwdata       in   32          write data, valid in the data phase
//  hready       out  1           transfer done / bus ready (also the slave's hready_in)
//  hresp        out  1           tied 0 (OKAY)
//  hrdata       out  32          read data, equals mem_rdata
//  mem_rd_en    out  1           one-cycle read request to cache_ctrl i_rd_en
//  mem_wr_en    out  1           one-cycle write request to cache_ctrl i_wr_en
//  mem_addr     out  32          {zeros, haddr_q[ADDR_WIDTH-1:2], 2'b00}
//  mem_wdata    out  32          write data (hwdata captured in the issue cycle)
//  mem_mask     out  4           byte-lane mask to cache_ctrl i_mask
//  mem_rdata    in   32          cache_ctrl o_data
//  mem_busy     in   1           cache_ctrl o_busy
//  cnt_rd       out  CNT_WIDTH   completed reads
//  cnt_hit      out  CNT_WIDTH   reads completed in the cycle right after issue (cache hit)
//  cnt_wait     out  CNT_WIDTH   cycles with hready=0
//  cnt_clr      in   1           synchronous clear of all three counters
// BEHAVIOUR
//  Reset: state=IDLE, hready=1, mem_rd_en=mem_wr_en=0, mem_addr/mem_wdata/mem_mask=0, counters=0.
//  Address phase accepted when hsel & htrans[1] & hready: latch haddr, hwrite, mask.
//  Mask: hsize 0 -> 4'b0001<<haddr[1:0]; 1 -> haddr[1]?4'b1100:4'b0011; 2 or >2 -> 4'b1111.
//  FSM:
//   IDLE  : accept -> ISSUE (hready drops next cycle); else stay, hready=1.
//   ISSUE : hready=0. If !mem_busy: pulse mem_rd_en or mem_wr_en for exactly this cycle
//           (write: mem_wdata<=hwdata), -> WAIT. If mem_busy: hold, no pulse.
//   WAIT  : hready=0 while mem_busy=1. First cycle with mem_busy=0 = completion:
//           hready=1, hrdata=mem_rdata valid (reads); same cycle a new accepted address phase
//           -> ISSUE, else -> IDLE.
//  Latency: read hit = 1 wait state (addr T0, issue T1, hready+data T2); miss/write = until busy low.
//  Never more than one outstanding request; rd_en and wr_en never high together.
//  Idle/BUSY htrans or hsel=0 while IDLE: no request, hready stays 1.
//  Counters: cnt_rd++ on read completion; cnt_hit++ when that completion is the first WAIT cycle;
//   cnt_wait++ every hready=0 cycle. All saturate at all-ones; cnt_clr wins over increment.
//  Reset mid-transfer: immediate return to IDLE, pulses dropped; cache_ctrl shares rst_x.
// TESTING
//  Word read, mem_busy low in first WAIT cycle, mem_rdata=32'hDEADBEEF -> hready low 1 cycle, hrdata=DEADBEEF, cnt_rd=cnt_hit=1.
//  Word read, mem_busy high 5 cycles after issue -> hready low 6 cycles, cnt_hit unchanged, cnt_wait+=6.
//  Byte write haddr=0x103, hwdata=0x11223344 -> one mem_wr_en pulse, mem_addr=0x100, mask=4'b1000, wdata=0x11223344.
//  Half write haddr=0x102 then back-to-back word read -> masks 1100 then 1111, second issue the cycle after first completion.
//  mem_busy held high in ISSUE 3 cycles -> no pulse until busy low, then exactly one pulse.
//  rst_x low during WAIT -> hready=1, mem_rd_en=0, counters 0; cnt_clr with increment -> counter 0.

Source files
------------

// File: rtl/ahbl_cache_bridge_if.sv
// rtl/ahbl_cache_bridge_if.sv - AHB-Lite slave side and cache_ctrl user-port signals of the bridge
interface ahbl_cache_bridge_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, mem_rdata, mem_busy,
    output hready, hresp, hrdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, mem_rdata, mem_busy,
    input  hready, hresp, hrdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/ahbl_cache_bridge.sv
// rtl/ahbl_cache_bridge.sv - AHB-Lite slave issuing single-pulse requests to cache_ctrl, with profiling counters
module ahbl_cache_bridge #(
  parameter int ADDR_WIDTH = 23,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_x,
  ahbl_cache_bridge_if.slave   bus,
  output logic [CNT_WIDTH-1:0] cnt_rd,
  output logic [CNT_WIDTH-1:0] cnt_hit,
  output logic [CNT_WIDTH-1:0] cnt_wait,
  input  logic                 cnt_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic                  write_q;
  logic [3:0]            mask_q;
  logic [31:0]           wdata_q;
  logic                  first_q;
  logic                  hready_c;
  logic                  issue;
  logic                  done;
  logic                  accept;
  logic [3:0]            mask_c;
  logic                  rd_inc;
  logic                  hit_inc;

  always_comb begin
    case (bus.hsize)
      3'd0:    mask_c = 4'b0001 << bus.haddr[1:0];
      3'd1:    mask_c = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: mask_c = 4'b1111;
    endcase
  end

  always_comb begin
    state_nx = state;
    hready_c = 1'b0;
    issue    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        hready_c = 1'b1;
        if (bus.hsel && bus.htrans[1]) state_nx = ISSUE;
      end
      ISSUE: begin
        if (!bus.mem_busy) begin
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // Completion cycle doubles as the next address phase, so back-to-back transfers lose no cycle.
        if (!bus.mem_busy) begin
          hready_c = 1'b1;
          done     = 1'b1;
          state_nx = (bus.hsel && bus.htrans[1]) ? ISSUE : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept        = bus.hsel & bus.htrans[1] & hready_c;
  assign bus.hready    = hready_c;
  assign bus.hresp     = 1'b0;
  assign bus.hrdata    = bus.mem_rdata;
  assign bus.mem_rd_en = issue & ~write_q;
  assign bus.mem_wr_en = issue & write_q;
  assign bus.mem_addr  = {{(32-ADDR_WIDTH){1'b0}}, addr_q, 2'b00};
  assign bus.mem_mask  = mask_q;
  // hwdata is only valid in the data phase, so it is passed straight through while issuing.
  assign bus.mem_wdata = (state == ISSUE && write_q) ? bus.hwdata : wdata_q;

  assign rd_inc  = done & ~write_q;
  assign hit_inc = rd_inc & first_q;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v, input logic inc);
    if (inc && (v != {CNT_WIDTH{1'b1}})) return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      mask_q  <= 4'b0000;
      wdata_q <= 32'h0;
      first_q <= 1'b0;
    end else begin
      state   <= state_nx;
      first_q <= issue;
      if (accept) begin
        addr_q  <= bus.haddr[ADDR_WIDTH-1:2];
        write_q <= bus.hwrite;
        mask_q  <= mask_c;
      end
      if (issue && write_q) wdata_q <= bus.hwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cnt_rd   <= '0;
      cnt_hit  <= '0;
      cnt_wait <= '0;
    end else if (cnt_clr) begin
      cnt_rd   <= '0;
      cnt_hit  <= '0;
      cnt_wait <= '0;
    end else begin
      cnt_rd   <= bump(cnt_rd, rd_inc);
      cnt_hit  <= bump(cnt_hit, hit_inc);
      cnt_wait <= bump(cnt_wait, ~hready_c);
    end
  end

endmodule

// File: tb/tb_ahbl_cache_bridge.sv
// tb/tb_ahbl_cache_bridge.sv - directed vector bench for ahbl_cache_bridge
module tb_ahbl_cache_bridge;
  logic        clk = 1'b0;
  logic        rst_x;
  logic        cnt_clr;
  logic [31:0] cnt_rd;
  logic [31:0] cnt_hit;
  logic [31:0] cnt_wait;

  ahbl_cache_bridge_if bus();

  ahbl_cache_bridge #(.ADDR_WIDTH(23), .CNT_WIDTH(32)) dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .bus      (bus),
    .cnt_rd   (cnt_rd),
    .cnt_hit  (cnt_hit),
    .cnt_wait (cnt_wait),
    .cnt_clr  (cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ib;
    int          wb;
    logic [3:0]  exp_mask;
    logic [31:0] exp_addr;
    int          exp_low;
    logic        exp_hit;
  } vec_t;

  vec_t        vecs[8];
  int          tests = 0;
  int          failed = 0;
  int          r_pulses, r_both, r_low;
  logic        r_wr, r_done;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_mask;
  logic [31:0] exp_rd, exp_hit, exp_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, " cnt_rd"}, cnt_rd, exp_rd);
    check({tag, " cnt_hit"}, cnt_hit, exp_hit);
    check({tag, " cnt_wait"}, cnt_wait, exp_wait);
  endtask

  // Called just after a rising edge with the bridge idle; models cache busy in ISSUE (ib) and WAIT (wb).
  task automatic xfer(input vec_t v, input bit clr_done);
    int   k, post;
    bit   issued, pulse;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = v.addr; bus.hwrite = v.wr;
    bus.hsize = v.size; bus.mem_busy = 1'b0; bus.mem_rdata = v.rdata;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = v.wdata;
    r_pulses = 0; r_both = 0; r_low = 0; r_wr = 1'b0; r_done = 1'b0;
    r_addr = 32'hx; r_mask = 4'hx; r_wdata = 32'hx; r_rdata = 32'hx;
    k = 0; post = 0; issued = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.mem_busy = issued ? (post < v.wb) : (k < v.ib);
      @(negedge clk);
      pulse = bus.mem_rd_en | bus.mem_wr_en;
      if (bus.mem_rd_en && bus.mem_wr_en) r_both++;
      if (pulse) begin
        r_pulses++;
        r_wr    = bus.mem_wr_en;
        r_addr  = bus.mem_addr;
        r_mask  = bus.mem_mask;
        r_wdata = bus.mem_wdata;
      end
      if (bus.hready) begin
        r_done  = 1'b1;
        r_rdata = bus.hrdata;
        if (clr_done) cnt_clr = 1'b1;
      end else begin
        r_low++;
      end
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      if (r_done) break;
      k++;
      if (pulse) begin
        issued = 1'b1;
        post   = 0;
      end else if (issued) begin
        post++;
      end
    end
    bus.mem_busy = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,         32'hDEADBEEF, 0, 0, 4'b1111, 32'h0000_0040, 1, 1'b1};
    vecs[1] = '{1'b0, 3'd2, 32'h0000_0080, 32'h0,         32'h1234_5678, 0, 5, 4'b1111, 32'h0000_0080, 6, 1'b0};
    vecs[2] = '{1'b1, 3'd0, 32'h0000_0103, 32'h1122_3344, 32'h0,         0, 0, 4'b1000, 32'h0000_0100, 1, 1'b0};
    vecs[3] = '{1'b1, 3'd1, 32'h0000_0102, 32'h5566_7788, 32'h0,         0, 1, 4'b1100, 32'h0000_0100, 2, 1'b0};
    vecs[4] = '{1'b1, 3'd1, 32'h0000_0200, 32'h99AA_BBCC, 32'h0,         1, 0, 4'b0011, 32'h0000_0200, 2, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 32'h0000_0301, 32'h0,         32'hA5A5_5A5A, 3, 0, 4'b0010, 32'h0000_0300, 4, 1'b1};
    vecs[6] = '{1'b0, 3'd3, 32'hFF80_0010, 32'h0,         32'h0BAD_F00D, 0, 2, 4'b1111, 32'h0000_0010, 3, 1'b0};
    vecs[7] = '{1'b1, 3'd0, 32'h0000_0002, 32'hCAFE_0001, 32'h0,         0, 0, 4'b0100, 32'h0000_0000, 1, 1'b0};

    rst_x = 1'b0; cnt_clr = 1'b0;
    bus.hsel = 1'b0; bus.haddr = 32'h0; bus.htrans = 2'b00; bus.hwrite = 1'b0;
    bus.hsize = 3'd0; bus.hwdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_busy = 1'b0;
    exp_rd = 0; exp_hit = 0; exp_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hready", bus.hready, 1'b1);
    check("reset hresp", bus.hresp, 1'b0);
    check("reset rd_en", bus.mem_rd_en, 1'b0);
    check("reset wr_en", bus.mem_wr_en, 1'b0);
    check("reset mem_addr", bus.mem_addr, 32'h0);
    check("reset mem_wdata", bus.mem_wdata, 32'h0);
    check("reset mem_mask", bus.mem_mask, 4'h0);
    check_cnt("reset");
    @(posedge clk); #1;
    rst_x = 1'b1;
    @(posedge clk); #1;

    // BUSY transfers and deselected NONSEQ must not start anything
    begin
      int pulses = 0, lows = 0;
      for (int c = 0; c < 5; c++) begin
        bus.hsel   = (c < 3);
        bus.htrans = (c < 3) ? 2'b01 : 2'b10;
        bus.haddr  = 32'h40;
        @(negedge clk);
        pulses += bus.mem_rd_en + bus.mem_wr_en;
        lows   += !bus.hready;
        @(posedge clk); #1;
      end
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      @(negedge clk);
      pulses += bus.mem_rd_en + bus.mem_wr_en;
      lows   += !bus.hready;
      @(posedge clk); #1;
      check("idle pulses", pulses, 0);
      check("idle hready low", lows, 0);
      check_cnt("idle");
    end

    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i], 1'b0);
      check($sformatf("v%0d done", i), r_done, 1'b1);
      check($sformatf("v%0d pulses", i), r_pulses, 1);
      check($sformatf("v%0d both", i), r_both, 0);
      check($sformatf("v%0d kind", i), r_wr, vecs[i].wr);
      check($sformatf("v%0d addr", i), r_addr, vecs[i].exp_addr);
      check($sformatf("v%0d mask", i), r_mask, vecs[i].exp_mask);
      check($sformatf("v%0d hready low", i), r_low, vecs[i].exp_low);
      if (vecs[i].wr) check($sformatf("v%0d wdata", i), r_wdata, vecs[i].wdata);
      else            check($sformatf("v%0d hrdata", i), r_rdata, vecs[i].rdata);
      exp_rd   += !vecs[i].wr;
      exp_hit  += vecs[i].exp_hit;
      exp_wait += vecs[i].exp_low;
      check_cnt($sformatf("v%0d", i));
    end

    // Half write then back-to-back word read accepted in the write's completion cycle
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h102; bus.hwrite = 1'b1; bus.hsize = 3'd1;
    bus.mem_busy = 1'b0;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("b2b wr_en", bus.mem_wr_en, 1'b1);
    check("b2b wr mask", bus.mem_mask, 4'b1100);
    check("b2b wr addr", bus.mem_addr, 32'h100);
    check("b2b wr wdata", bus.mem_wdata, 32'hAABB_CCDD);
    @(posedge clk); #1;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h400; bus.hwrite = 1'b0; bus.hsize = 3'd2;
    bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("b2b wr complete", bus.hready, 1'b1);
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(negedge clk);
    check("b2b rd_en", bus.mem_rd_en, 1'b1);
    check("b2b rd mask", bus.mem_mask, 4'b1111);
    check("b2b rd addr", bus.mem_addr, 32'h400);
    check("b2b rd hready", bus.hready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b rd complete", bus.hready, 1'b1);
    check("b2b rd hrdata", bus.hrdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    exp_rd += 1; exp_hit += 1; exp_wait += 2;
    check_cnt("b2b");

    // Reset asserted while waiting on a miss
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h800; bus.hwrite = 1'b0; bus.hsize = 3'd2;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    @(posedge clk); #1;
    bus.mem_busy = 1'b1;
    @(posedge clk); #1;
    rst_x = 1'b0;
    #1;
    check("rst hready", bus.hready, 1'b1);
    check("rst rd_en", bus.mem_rd_en, 1'b0);
    check("rst mem_addr", bus.mem_addr, 32'h0);
    exp_rd = 0; exp_hit = 0; exp_wait = 0;
    check_cnt("rst");
    @(posedge clk); #1;
    bus.mem_busy = 1'b0;
    rst_x = 1'b1;
    @(posedge clk); #1;

    xfer(vecs[0], 1'b0);
    exp_rd = 1; exp_hit = 1; exp_wait = 1;
    check_cnt("post-rst");

    // Clear coinciding with a read completion wins over the increment
    xfer(vecs[0], 1'b1);
    check("clr done", r_done, 1'b1);
    exp_rd = 0; exp_hit = 0; exp_wait = 0;
    check_cnt("clr");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
